// File: rtl/scff_bist_pkg.sv
// rtl/scff_bist_pkg.sv - shared types and defaults for the scan-chain BIST controller
// Purpose: FSM state encoding and default parameter values used by scff_bist_ctrl.
// Ports: none (package).
package scff_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    INJECT,
    SHIFT,
    CHECK,
    DONE
  } state_t;

  localparam int ERR_W_DEF       = 16;
  localparam int POST_CHECKS_DEF = 3;

endpackage

// File: rtl/scff_bist_ctrl.sv
// rtl/scff_bist_ctrl.sv - scan-chain pulse driver/checker for the fabric scan chain
// Purpose: flushes the chain with zeros, injects a one-cycle pulse at sc_head and
//   checks that sc_tail shows exactly that pulse SCANCHAIN_SIZE cycles later,
//   followed by POST_CHECKS zero samples.
// Ports:
//   clk           in   operating clock (shared with the fabric)
//   Reset         in   synchronous active-high reset
//   start         in   one-cycle run request, honoured only in IDLE/DONE
//   Test_en       out  scan enable, high while the run is in progress
//   sc_head       out  registered scan-chain input
//   sc_tail       in   scan-chain output from the fabric
//   busy          out  run in progress
//   done          out  run finished, held until next start or Reset
//   pass          out  done with zero errors
//   err_count     out  saturating count of mismatching tail samples
//   first_err_cyc out  counter value at the first mismatch (0 if none)
module scff_bist_ctrl
  import scff_bist_pkg::*;
#(
  parameter int SCANCHAIN_SIZE = 2304,
  parameter int POST_CHECKS    = POST_CHECKS_DEF,
  parameter int ERR_W          = ERR_W_DEF,
  localparam int CNT_W         = $clog2(SCANCHAIN_SIZE + POST_CHECKS + 1)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  output logic             Test_en,
  output logic             sc_head,
  input  logic             sc_tail,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_cyc
);

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(SCANCHAIN_SIZE - 1);
  localparam logic [CNT_W-1:0] PULSE_CYC  = CNT_W'(SCANCHAIN_SIZE);
  localparam logic [CNT_W-1:0] LAST_CHECK = CNT_W'(SCANCHAIN_SIZE + POST_CHECKS);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic             sample_en;
  logic             expect_one;
  logic             mismatch;
  logic             run_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic [CNT_W-1:0] first_nxt;

  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // The single counter times FLUSH (0..N-1), then restarts at INJECT (0) and
  // runs through SHIFT and CHECK, so its value equals the pulse's position.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = FLUSH;
      FLUSH:      if (cnt == LAST_SHIFT) next_state = INJECT;
      INJECT:     next_state = SHIFT;
      SHIFT:      if (cnt == LAST_SHIFT) next_state = CHECK;
      CHECK:      if (cnt == LAST_CHECK) next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    sample_en  = (state == SHIFT) || (state == CHECK);
    expect_one = (state == CHECK) && (cnt == PULSE_CYC);
    mismatch   = sample_en && (sc_tail != expect_one);
    run_nxt    = (next_state == FLUSH) || (next_state == INJECT) ||
                 (next_state == SHIFT) || (next_state == CHECK);
    err_nxt    = err_count;
    first_nxt  = first_err_cyc;
    if ((state == IDLE) || (state == DONE)) begin
      if (start) begin
        err_nxt   = '0;
        first_nxt = '0;
      end
    end else if (mismatch) begin
      // err_count only leaves zero on a mismatch, so zero marks "no error yet"
      if (err_count == '0) first_nxt = cnt;
      if (err_count != '1) err_nxt = err_count + 1'b1;
    end
  end

  // Outputs are registered from next-state so they line up with the state.
  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt           <= '0;
      Test_en       <= 1'b0;
      sc_head       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_cyc <= '0;
    end else begin
      err_count     <= err_nxt;
      first_err_cyc <= first_nxt;
      Test_en       <= run_nxt;
      busy          <= run_nxt;
      sc_head       <= (next_state == INJECT);
      done          <= (next_state == DONE);
      pass          <= (next_state == DONE) && (err_nxt == '0);
      if ((next_state == INJECT) || ((next_state == FLUSH) && (state != FLUSH)))
        cnt <= '0;
      else if (run_nxt)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_scff_bist_ctrl.sv
// tb/tb_scff_bist_ctrl.sv - self-checking scoreboard bench for scff_bist_ctrl
module tb_scff_bist_ctrl;

  localparam int N  = 8;
  localparam int PC = 3;
  localparam int CW = $clog2(N + PC + 1);

  typedef struct {
    int err;
    int first;
    int pass;
    int cycles;
    int head_at;
    int head_cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic          start2 = 1'b0;
  logic          Test_en, sc_head, sc_tail, busy, done, pass;
  logic [15:0]   err_count;
  logic [CW-1:0] first_err_cyc;
  logic          Test_en2, sc_head2, busy2, done2, pass2;
  logic [1:0]    err_count2;
  logic [CW-1:0] first_err_cyc2;

  logic [N-1:0]  chain = '0;
  int            mode = 0;  // 0 good, 1 stuck-0, 2 stuck-1, 3 one flop short
  int            checks = 0;
  int            errors = 0;
  exp_t          sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) if (Test_en) chain <= {chain[N-2:0], sc_head};

  assign sc_tail = (mode == 0) ? chain[N-1] :
                   (mode == 1) ? 1'b0 :
                   (mode == 2) ? 1'b1 : chain[N-2];

  scff_bist_ctrl #(.SCANCHAIN_SIZE(N), .POST_CHECKS(PC), .ERR_W(16)) dut (
    .clk(clk), .Reset(Reset), .start(start), .Test_en(Test_en),
    .sc_head(sc_head), .sc_tail(sc_tail), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_cyc(first_err_cyc)
  );

  scff_bist_ctrl #(.SCANCHAIN_SIZE(N), .POST_CHECKS(PC), .ERR_W(2)) dut_sat (
    .clk(clk), .Reset(Reset), .start(start2), .Test_en(Test_en2),
    .sc_head(sc_head2), .sc_tail(1'b1), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err_count2), .first_err_cyc(first_err_cyc2)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int m, input bit extra_start, input int e_err,
                     input int e_first, input int e_pass);
    exp_t e, g;
    int cyc, head_at, head_cnt;
    mode = m;
    e.err = e_err; e.first = e_first; e.pass = e_pass;
    e.cycles = 2 * N + PC + 1; e.head_at = N; e.head_cnt = 1;
    sb.push_back(e);
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    cyc = 0; head_at = -1; head_cnt = 0;
    while (cyc < 100) begin
      @(posedge clk) #1;
      cyc++;
      if (extra_start && cyc == 5) start = 1'b1;
      else start = 1'b0;
      if (sc_head) begin
        head_cnt++;
        head_at = cyc;
      end
      if (done) break;
    end
    start = 1'b0;
    check("done_seen", int'(done), 1);
    g = sb.pop_front();
    check("cycles", cyc, g.cycles);
    check("err_count", int'(err_count), g.err);
    check("first_err_cyc", int'(first_err_cyc), g.first);
    check("pass", int'(pass), g.pass);
    check("head_cnt", head_cnt, g.head_cnt);
    check("head_at", head_at, g.head_at);
    repeat (2) @(posedge clk);
    #1 check("done_held", int'(done), 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_test_en"}, int'(Test_en), 0);
    check({tag, "_sc_head"}, int'(sc_head), 0);
    check({tag, "_err"}, int'(err_count), 0);
    check({tag, "_first"}, int'(first_err_cyc), 0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    @(negedge clk) Reset = 1'b0;

    run(0, 1'b1, 0, 0, 1);
    run(1, 1'b0, 1, 8, 0);
    run(2, 1'b0, 10, 1, 0);
    run(3, 1'b0, 2, 7, 0);

    // abort mid-SHIFT, with start asserted alongside Reset
    mode = 2;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (11) @(negedge clk);
    check("mid_shift_busy", int'(busy), 1);
    Reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_idle("abort");
    Reset = 1'b0;
    start = 1'b0;
    run(0, 1'b0, 0, 0, 1);

    // saturating counter instance
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("sat_done", int'(done2), 1);
    check("sat_err", int'(err_count2), 3);
    check("sat_pass", int'(pass2), 0);
    check("sat_first", int'(first_err_cyc2), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
